// File: rtl/main_memory_bank.sv
// main_memory_bank: line-organised main memory with fixed access latency behind the arbiter
module main_memory_bank #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int LATENCY = 4,
    parameter int LINE_W  = 66
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt_CPU,
    input  logic              gnt_EXT,
    input  logic              req_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] write_line,
    output logic [LINE_W-1:0] read_line,
    output logic              busy,
    output logic              read_mm_completed,
    output logic              master_EXT,
    output logic              err_no_grant
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [LINE_W-1:0] op_line;
    logic [LINE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              accept;
    logic              commit;

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("main_memory_bank: LATENCY must be within 1..255");
    end
    if (LINE_W != 66) begin : g_bad_line_w
        $error("main_memory_bank: LINE_W must be 66");
    end

    // the DONE cycle also takes a new request so back-to-back ops run every LATENCY+1 cycles
    assign accept = (state != ACCESS) && req_valid && (gnt_CPU || gnt_EXT);
    assign commit = (state == ACCESS) && (cnt == 8'd0);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: ACCESS counts down to commit, everything else waits for an accepted request
    always_comb begin
        state_nxt = (state == ACCESS) ? (commit ? DONE : ACCESS) : (accept ? ACCESS : IDLE);
    end

    // outputs decoded straight from the state register
    always_comb begin
        busy              = (state != IDLE);
        read_mm_completed = (state == DONE);
    end

    // request latch, latency counter, valid bits and read result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            op_we        <= 1'b0;
            op_addr      <= '0;
            op_line      <= '0;
            master_EXT   <= 1'b0;
            read_line    <= '0;
            valid        <= '0;
            err_no_grant <= 1'b0;
        end else begin
            err_no_grant <= (state == IDLE) && req_valid && !gnt_CPU && !gnt_EXT;
            if (accept) begin
                op_we      <= we;
                op_addr    <= addr;
                op_line    <= write_line;
                master_EXT <= gnt_EXT;
                cnt        <= 8'(LATENCY - 1);
            end else if (state == ACCESS && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit && op_we)  valid[op_addr] <= 1'b1;
            if (commit && !op_we) read_line <= valid[op_addr] ? mem[op_addr] : '0;
        end
    end

    // line array is not reset; a reset forces IDLE so an aborted write never lands
    always_ff @(posedge clk) begin
        if (commit && op_we) mem[op_addr] <= op_line;
    end
endmodule

// File: tb/tb_main_memory_bank.sv
// tb_main_memory_bank: directed self-checking bench for main_memory_bank (ADDR_W=4, LATENCY=4)
module tb_main_memory_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gnt_CPU = 1'b0;
    logic        gnt_EXT = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [65:0] write_line = '0;
    logic [65:0] read_line;
    logic        busy;
    logic        read_mm_completed;
    logic        master_EXT;
    logic        err_no_grant;
    int          tests = 0;
    int          fails = 0;

    localparam logic [65:0] L5 = 66'h2_DEADBEEF_01234567;
    localparam logic [65:0] L7 = 66'h1_00000000_CAFEF00D;
    localparam logic [65:0] L9 = 66'h3_99999999_99999999;
    localparam logic [65:0] L1 = 66'h3_11111111_11111111;
    localparam logic [65:0] L2 = 66'h0_22222222_22222222;

    main_memory_bank #(.ADDR_W(4), .LATENCY(4)) dut (
        .clk(clk),
        .reset(reset),
        .gnt_CPU(gnt_CPU),
        .gnt_EXT(gnt_EXT),
        .req_valid(req_valid),
        .we(we),
        .addr(addr),
        .write_line(write_line),
        .read_line(read_line),
        .busy(busy),
        .read_mm_completed(read_mm_completed),
        .master_EXT(master_EXT),
        .err_no_grant(err_no_grant)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one request at the next edge and follow it through its five busy cycles,
    // ending in the completion cycle so a following call issues at the first legal edge
    task automatic do_op(input logic w, input logic [3:0] a, input logic [65:0] d,
                         input logic c, input logic e, input logic [65:0] exp_rl,
                         input logic exp_m, input string tag);
        req_valid = 1'b1; we = w; addr = a; write_line = d; gnt_CPU = c; gnt_EXT = e;
        step();
        req_valid = 1'b0; we = 1'b0; write_line = '0; gnt_CPU = 1'b0; gnt_EXT = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 66'(busy), 66'(1));
            chk($sformatf("%s_done%0d", tag, k), 66'(read_mm_completed), 66'(k == 5));
            if (k < 5) step();
        end
        chk({tag, "_read_line"}, read_line, exp_rl);
        chk({tag, "_master"}, 66'(master_EXT), 66'(exp_m));
    endtask

    initial begin
        repeat (3) step();
        chk("rst_busy", 66'(busy), 66'(0));
        chk("rst_done", 66'(read_mm_completed), 66'(0));
        chk("rst_err", 66'(err_no_grant), 66'(0));
        chk("rst_master", 66'(master_EXT), 66'(0));
        chk("rst_read_line", read_line, 66'h0);
        reset = 1'b1;
        step();
        do_op(1'b0, 4'd3, '0, 1'b1, 1'b0, 66'h0, 1'b0, "t1_rd3");
        step();
        chk("t1_idle_busy", 66'(busy), 66'(0));
        do_op(1'b1, 4'd5, L5, 1'b0, 1'b1, 66'h0, 1'b1, "t2_wr5");
        do_op(1'b0, 4'd5, '0, 1'b0, 1'b1, L5, 1'b1, "t2_rd5");
        step();
        chk("t2_idle_busy", 66'(busy), 66'(0));
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t3_err_pulse", 66'(err_no_grant), 66'(1));
        chk("t3_busy", 66'(busy), 66'(0));
        chk("t3_done", 66'(read_mm_completed), 66'(0));
        step();
        chk("t3_err_clear", 66'(err_no_grant), 66'(0));
        chk("t3_busy_after", 66'(busy), 66'(0));
        chk("t3_done_after", 66'(read_mm_completed), 66'(0));
        req_valid = 1'b1; we = 1'b1; addr = 4'd7; write_line = L7; gnt_CPU = 1'b1;
        step();
        we = 1'b0; write_line = '0; gnt_CPU = 1'b0; addr = 4'd5;
        for (int k = 1; k <= 5; k++) begin
            req_valid = (k == 4) || (k < 4 && k % 2 == 1);
            gnt_EXT = (k == 4);
            chk($sformatf("t4_busy%0d", k), 66'(busy), 66'(1));
            chk($sformatf("t4_done%0d", k), 66'(read_mm_completed), 66'(k == 5));
            if (k < 5) step();
        end
        req_valid = 1'b0; gnt_EXT = 1'b0;
        chk("t4_read_line_kept", read_line, L5);
        chk("t4_master", 66'(master_EXT), 66'(0));
        step();
        chk("t4_idle_busy", 66'(busy), 66'(0));
        chk("t4_idle_done", 66'(read_mm_completed), 66'(0));
        step();
        chk("t4_no_second_done", 66'(read_mm_completed), 66'(0));
        chk("t4_no_second_busy", 66'(busy), 66'(0));
        do_op(1'b0, 4'd7, '0, 1'b1, 1'b0, L7, 1'b0, "t4_rd7");
        step();
        req_valid = 1'b1; we = 1'b1; addr = 4'd9; write_line = L9; gnt_EXT = 1'b1;
        step();
        req_valid = 1'b0; we = 1'b0; write_line = '0; gnt_EXT = 1'b0;
        step();
        step();
        chk("t5_busy_before", 66'(busy), 66'(1));
        chk("t5_master_before", 66'(master_EXT), 66'(1));
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", 66'(busy), 66'(0));
        chk("t5_rst_done", 66'(read_mm_completed), 66'(0));
        chk("t5_rst_master", 66'(master_EXT), 66'(0));
        chk("t5_rst_read_line", read_line, 66'h0);
        chk("t5_rst_err", 66'(err_no_grant), 66'(0));
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t5_no_done%0d", k), 66'(read_mm_completed), 66'(0));
        end
        do_op(1'b0, 4'd9, '0, 1'b1, 1'b0, 66'h0, 1'b0, "t5_rd9");
        step();
        do_op(1'b1, 4'd1, L1, 1'b1, 1'b0, 66'h0, 1'b0, "t6_wr1");
        do_op(1'b1, 4'd2, L2, 1'b0, 1'b1, 66'h0, 1'b1, "t6_wr2");
        do_op(1'b0, 4'd1, '0, 1'b1, 1'b0, L1, 1'b0, "t6_rd1");
        do_op(1'b0, 4'd2, '0, 1'b1, 1'b1, L2, 1'b1, "t6_rd2");
        step();
        chk("t6_idle_busy", 66'(busy), 66'(0));
        chk("t6_idle_done", 66'(read_mm_completed), 66'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
